// File: rtl/counter_ram_pkg.sv
// Shared types and default widths for the counter RAM filler.
package counter_ram_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_DEPTH  = 256;
  localparam int unsigned DEF_STEP   = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    READ = 2'd2
  } state_e;

  // Smallest r such that 2**r >= v.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ram_addr_counter.sv
// Loadable, enable-gated wrapping address counter feeding mem_addr during a fill.
module ram_addr_counter
  import counter_ram_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_base,
  input  logic              i_en,
  output logic [ADDR_W-1:0] o_cnt
);

  logic [ADDR_W-1:0] r_cnt;

  // Wraps silently past the top of the address space.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_cnt <= '0;
    else if (i_load) r_cnt <= i_base;
    else if (i_en)   r_cnt <= r_cnt + ADDR_W'(1);
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/counter_ram_filler.sv
// Writes an incrementing pattern into DEPTH RAM words, then hands the address bus to the host.
// CNT_FILL_READBACK_EN: when defined, a completed fill enters READ and mem_addr follows rd_addr.
module counter_ram_filler
  import counter_ram_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned STEP   = DEF_STEP
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wren,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W = clog2(DEPTH + 1);

  state_e            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_idx, w_idx_nxt;
  logic [DATA_W-1:0] r_pat, w_pat_nxt;
  logic [DATA_W-1:0] r_mem_data, w_mem_data_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic              r_wren, w_wren_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              w_load, w_cnt_en, w_last;
  logic [ADDR_W-1:0] w_cnt;

  ram_addr_counter #(.ADDR_W(ADDR_W)) u_addr_cnt (
    .clk    (clk),
    .rst_n  (reset_n),
    .i_load (w_load),
    .i_base (base_addr),
    .i_en   (w_cnt_en),
    .o_cnt  (w_cnt)
  );

  // Index DEPTH is the completion cycle that follows the last write.
  assign w_last = (r_idx == CNT_W'(DEPTH));

`ifndef CNT_FILL_READBACK_EN
  logic w_rd_addr_unused;
  assign w_rd_addr_unused = ^rd_addr;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_pat_nxt       = r_pat;
    w_mem_data_nxt  = r_mem_data;
    w_mem_addr_nxt  = r_mem_addr;
    w_wren_nxt      = 1'b0;
    w_busy_nxt      = 1'b0;
    w_done_nxt      = r_done;
    w_load          = 1'b0;
    w_cnt_en        = 1'b0;
    if (stop) begin
      w_state_nxt = IDLE;
      w_done_nxt  = 1'b0;
    end else if (start && (r_state != FILL)) begin
      w_load      = 1'b1;
      w_idx_nxt   = '0;
      w_pat_nxt   = '0;
      w_done_nxt  = 1'b0;
      w_state_nxt = FILL;
    end else begin
      case (r_state)
        FILL: begin
          if (w_last) begin
            w_done_nxt  = 1'b1;
`ifdef CNT_FILL_READBACK_EN
            w_state_nxt = READ;
`else
            w_state_nxt = IDLE;
`endif
          end else begin
            w_cnt_en       = 1'b1;
            w_wren_nxt     = 1'b1;
            w_busy_nxt     = 1'b1;
            w_mem_addr_nxt = w_cnt;
            w_mem_data_nxt = r_pat;
            w_pat_nxt      = r_pat + DATA_W'(STEP);
            w_idx_nxt      = r_idx + CNT_W'(1);
          end
        end
`ifdef CNT_FILL_READBACK_EN
        READ: w_mem_addr_nxt = rd_addr;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_pat      <= '0;
      r_mem_data <= '0;
      r_mem_addr <= '0;
      r_wren     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_pat      <= w_pat_nxt;
      r_mem_data <= w_mem_data_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_wren     <= w_wren_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign mem_data = r_mem_data;
  assign mem_addr = r_mem_addr;
  assign mem_wren = r_wren;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_counter_ram_filler.sv
// Self-checking bench: default instance plus a DEPTH=32/STEP=3 instance for the wrap case.
module tb_counter_ram_filler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] base_addr = '0;
  logic [15:0] rd_addr = '0;

  logic [7:0]  d_data, w_data, c_data;
  logic [15:0] d_addr, w_addr, c_addr;
  logic        d_wren, w_wren, c_wren;
  logic        d_busy, w_busy, c_busy;
  logic        d_done, w_done, c_done;
  logic        sel_w = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  counter_ram_filler u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .base_addr(base_addr), .rd_addr(rd_addr),
    .mem_data(d_data), .mem_addr(d_addr), .mem_wren(d_wren), .busy(d_busy), .done(d_done)
  );

  counter_ram_filler #(.DATA_W(8), .ADDR_W(16), .DEPTH(32), .STEP(3)) u_dut_w (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .base_addr(base_addr), .rd_addr(rd_addr),
    .mem_data(w_data), .mem_addr(w_addr), .mem_wren(w_wren), .busy(w_busy), .done(w_done)
  );

  assign c_data = sel_w ? w_data : d_data;
  assign c_addr = sel_w ? w_addr : d_addr;
  assign c_wren = sel_w ? w_wren : d_wren;
  assign c_busy = sel_w ? w_busy : d_busy;
  assign c_done = sel_w ? w_done : d_done;

  always #5 clk = ~clk;

  // Reference model: word i of a fill from base b with increment s.
  function automatic logic [15:0] m_addr(input logic [15:0] b, input int i);
    return 16'((32'(b) + i) % 65536);
  endfunction

  function automatic logic [7:0] m_data(input int i, input int s);
    return 8'((i * s) % 256);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    tick(); tick();
    n_tests++;
    if ({d_data, d_addr, d_wren, d_busy, d_done} !== 27'd0)
      begin n_fail++; $display("FAIL reset_init got data=%h addr=%h wren=%b busy=%b done=%b need all 0", d_data, d_addr, d_wren, d_busy, d_done); end
    reset_n = 1'b1;
    tick(); tick();
    n_tests++;
    if ({d_wren, d_busy} !== 2'b00)
      begin n_fail++; $display("FAIL reset_idle got wren=%b busy=%b need 0 0", d_wren, d_busy); end
    base_addr = 16'h0000; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (101) tick();
    n_tests++;
    if ({d_addr, d_data, d_wren} !== {m_addr(16'h0000, 100), m_data(100, 1), 1'b1})
      begin n_fail++; $display("FAIL reset_word100 got addr=%h data=%h wren=%b need addr=0064 data=64 wren=1", d_addr, d_data, d_wren); end
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if ({d_data, d_addr, d_wren, d_busy, d_done, w_data, w_addr, w_wren, w_busy, w_done} !== 54'd0)
      begin n_fail++; $display("FAIL reset_midfill got data=%h addr=%h wren=%b busy=%b done=%b need all 0", d_data, d_addr, d_wren, d_busy, d_done); end
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    n_tests++;
    if ({d_wren, d_busy, d_done} !== 3'b000)
      begin n_fail++; $display("FAIL reset_stays_idle got wren=%b busy=%b done=%b need 0 0 0", d_wren, d_busy, d_done); end
  endtask

  task automatic test_basic_fill();
    logic [15:0] b;
    sel_w = 1'b0;
    for (int k = 0; k < 3; k++) begin
      b = (k == 0) ? 16'h1000 : 16'($urandom);
      base_addr = b; start = 1'b1;
      tick();
      start = 1'b0;
      base_addr = 16'($urandom);
      n_tests++;
      if ({c_wren, c_busy} !== 2'b00)
        begin n_fail++; $display("FAIL basic_pre k=%0d got wren=%b busy=%b need 0 0", k, c_wren, c_busy); end
      for (int i = 0; i < 256; i++) begin
        tick();
        n_tests++;
        if ({c_addr, c_data, c_wren, c_busy, c_done} !== {m_addr(b, i), m_data(i, 1), 3'b110})
          begin n_fail++; $display("FAIL basic_word k=%0d i=%0d got addr=%h data=%h wren=%b busy=%b done=%b need addr=%h data=%h 1 1 0", k, i, c_addr, c_data, c_wren, c_busy, c_done, m_addr(b, i), m_data(i, 1)); end
      end
      tick();
      n_tests++;
      if ({c_wren, c_busy, c_done} !== 3'b001)
        begin n_fail++; $display("FAIL basic_done k=%0d got wren=%b busy=%b done=%b need 0 0 1", k, c_wren, c_busy, c_done); end
      tick();
      n_tests++;
      if ({c_wren, c_done} !== 2'b01)
        begin n_fail++; $display("FAIL basic_after k=%0d got wren=%b done=%b need 0 1", k, c_wren, c_done); end
    end
  endtask

  task automatic test_wrap();
    go_idle();
    sel_w = 1'b1;
    base_addr = 16'hFFF0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      tick();
      n_tests++;
      if ({c_addr, c_data, c_wren} !== {m_addr(16'hFFF0, i), m_data(i, 3), 1'b1})
        begin n_fail++; $display("FAIL wrap_word i=%0d got addr=%h data=%h wren=%b need addr=%h data=%h 1", i, c_addr, c_data, c_wren, m_addr(16'hFFF0, i), m_data(i, 3)); end
    end
    tick();
    n_tests++;
    if ({c_wren, c_busy, c_done} !== 3'b001)
      begin n_fail++; $display("FAIL wrap_done got wren=%b busy=%b done=%b need 0 0 1", c_wren, c_busy, c_done); end
    sel_w = 1'b0;
    go_idle();
  endtask

  task automatic test_readback();
    logic [15:0] b, r, exp;
    go_idle();
    b = 16'($urandom);
    base_addr = b; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (257) tick();
    n_tests++;
    if ({d_wren, d_done} !== 2'b01)
      begin n_fail++; $display("FAIL rb_done got wren=%b done=%b need 0 1", d_wren, d_done); end
    for (int k = 0; k < 5; k++) begin
      r = (k == 0) ? 16'h1234 : 16'($urandom);
      rd_addr = r;
      tick();
`ifdef CNT_FILL_READBACK_EN
      exp = r;
`else
      exp = m_addr(b, 255);
`endif
      n_tests++;
      if ({d_addr, d_wren, d_done} !== {exp, 2'b01})
        begin n_fail++; $display("FAIL rb_addr k=%0d got addr=%h wren=%b done=%b need addr=%h 0 1", k, d_addr, d_wren, d_done, exp); end
    end
  endtask

  task automatic test_stop();
    logic [15:0] b;
    start = 1'b1; stop = 1'b1; base_addr = 16'($urandom);
    tick();
    start = 1'b0; stop = 1'b0;
    n_tests++;
    if ({d_wren, d_busy, d_done} !== 3'b000)
      begin n_fail++; $display("FAIL stop_collide got wren=%b busy=%b done=%b need 0 0 0", d_wren, d_busy, d_done); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++;
      if ({d_wren, d_busy} !== 2'b00)
        begin n_fail++; $display("FAIL stop_collide_idle k=%0d got wren=%b busy=%b need 0 0", k, d_wren, d_busy); end
    end
    b = 16'($urandom);
    base_addr = b; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (11) tick();
    n_tests++;
    if ({d_addr, d_wren} !== {m_addr(b, 10), 1'b1})
      begin n_fail++; $display("FAIL stop_word10 got addr=%h wren=%b need addr=%h 1", d_addr, d_wren, m_addr(b, 10)); end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    n_tests++;
    if ({d_wren, d_busy, d_done} !== 3'b000)
      begin n_fail++; $display("FAIL stop_midfill got wren=%b busy=%b done=%b need 0 0 0", d_wren, d_busy, d_done); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++;
      if (d_wren !== 1'b0)
        begin n_fail++; $display("FAIL stop_no_more_writes k=%0d got wren=%b need 0", k, d_wren); end
    end
  endtask

  task automatic test_restart();
    logic [15:0] b1, b2;
    go_idle();
    b1 = 16'($urandom);
    b2 = b1 ^ 16'h8000;
    base_addr = b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (i == 50) begin start = 1'b1; base_addr = b2; end
      else start = 1'b0;
      n_tests++;
      if ({d_addr, d_data, d_wren} !== {m_addr(b1, i), m_data(i, 1), 1'b1})
        begin n_fail++; $display("FAIL restart_ignore i=%0d got addr=%h data=%h wren=%b need addr=%h data=%h 1", i, d_addr, d_data, d_wren, m_addr(b1, i), m_data(i, 1)); end
    end
    start = 1'b0;
    tick();
    n_tests++;
    if ({d_wren, d_busy, d_done} !== 3'b001)
      begin n_fail++; $display("FAIL restart_first_done got wren=%b busy=%b done=%b need 0 0 1", d_wren, d_busy, d_done); end
    tick();
    base_addr = 16'h2000; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      tick();
      n_tests++;
      if ({d_addr, d_data, d_wren, d_busy, d_done} !== {m_addr(16'h2000, i), m_data(i, 1), 3'b110})
        begin n_fail++; $display("FAIL restart_fill i=%0d got addr=%h data=%h wren=%b busy=%b done=%b need addr=%h data=%h 1 1 0", i, d_addr, d_data, d_wren, d_busy, d_done, m_addr(16'h2000, i), m_data(i, 1)); end
    end
    tick();
    n_tests++;
    if ({d_wren, d_busy, d_done} !== 3'b001)
      begin n_fail++; $display("FAIL restart_done got wren=%b busy=%b done=%b need 0 0 1", d_wren, d_busy, d_done); end
  endtask

  initial begin
    test_reset();
    test_basic_fill();
    test_wrap();
    test_readback();
    test_stop();
    test_restart();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
